spi_cmd_arbiter: RTL and testbench

//  Shares one spi_master_reg instance among NUM_REQ command sources (e.g. init sequencer, host bridge, monitor).

---
 rtl/spi_cmd_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// spi_cmd_arbiter
//
// Shares a single SPI master (spi_master_reg) among NUM_REQ command sources.
// Requesters are served round-robin, one SPI frame per grant. The MISO word
// captured during the frame is returned to the requester that issued it.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   defined   -> watchdog aborts a frame after TIMEOUT_CYC cycles in the
//                WAIT_BUSY/WAIT_DONE states (err pulse, rsp_data = 0)
//   undefined -> no watchdog, err tied to 0, the FSM waits indefinitely
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   WIDTH        SPI frame width, equal to the master's WIDTH
//   TIMEOUT_CYC  watchdog limit in sys_clk cycles (macro builds only)
//
// Ports
//   sys_clk       system clock, rising edge
//   n_rst         asynchronous active-low reset
//   req_valid     per-requester command pending (held until req_ack)
//   req_data      packed commands, requester i at [i*WIDTH +: WIDTH]
//   req_ack       one-hot pulse: command handed to the SPI master
//   rsp_valid     one-hot pulse: frame finished, rsp_data valid
//   rsp_data      MISO word of the last finished frame
//   err           watchdog abort pulse
//   spi_data      to master in_data
//   spi_ena       to master in_ena
//   spi_busy      from master busy
//   spi_miso      from master miso_reg
//   spi_miso_ena  from master miso_reg_ena
// -----------------------------------------------------------------------------
module spi_cmd_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned WIDTH       = 24,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic                     sys_clk,
   input  logic                     n_rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ack,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     err,
   output logic [WIDTH-1:0]         spi_data,
   output logic                     spi_ena,
   input  logic                     spi_busy,
   input  logic [WIDTH-1:0]         spi_miso,
   input  logic                     spi_miso_ena
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      gnt_q, gnt_d;
   logic [WIDTH-1:0]   spi_data_q, spi_data_d;
   logic [WIDTH-1:0]   miso_q, miso_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

   logic               arb_found;
   logic [IW-1:0]      arb_idx;
   logic [IW:0]        arb_sum;
   logic [IW-1:0]      arb_cand;
   logic [WIDTH-1:0]   arb_data;
   logic [NUM_REQ-1:0] gnt_onehot;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               err_q, err_d;
`endif

   // Round-robin search: first pending requester at or after ptr_q, wrapping.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_sum   = '0;
      arb_cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         arb_sum = {1'b0, ptr_q} + (IW+1)'(k);
         if (arb_sum >= (IW+1)'(NUM_REQ)) begin
            arb_sum = arb_sum - (IW+1)'(NUM_REQ);
         end
         arb_cand = arb_sum[IW-1:0];
         if (!arb_found && req_valid[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   always_comb begin
      arb_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (arb_idx == IW'(k)) begin
            arb_data = req_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      gnt_onehot        = '0;
      gnt_onehot[gnt_q] = 1'b1;
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      spi_data_d  = spi_data_q;
      miso_d      = miso_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (arb_found && !spi_busy) begin
               gnt_d      = arb_idx;
               spi_data_d = arb_data;
               miso_d     = '0;
               ptr_d      = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT_BUSY: begin
            if (spi_miso_ena) begin
               miso_d = spi_miso;
            end
            if (spi_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (spi_miso_ena) begin
               miso_d = spi_miso;
            end
            if (!spi_busy) begin
               // A MISO strobe coinciding with the busy fall is taken directly
               // so rsp_data carries it on the same edge as rsp_valid.
               rsp_valid_d = gnt_onehot;
               rsp_data_d  = spi_miso_ena ? spi_miso : miso_q;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      // Watchdog overrides a normal completion landing on the same cycle.
      if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            err_d       = 1'b1;
            rsp_valid_d = gnt_onehot;
            rsp_data_d  = '0;
            state_d     = IDLE;
         end
      end
`endif
   end

   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         spi_data_q  <= '0;
         miso_q      <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         spi_data_q  <= spi_data_d;
         miso_q      <= miso_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign spi_ena   = (state_q == ISSUE);
   assign req_ack   = spi_ena ? gnt_onehot : '0;
   assign spi_data  = spi_data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_arbiter
//
// Self-checking bench for spi_cmd_arbiter. A behavioural SPI master answers
// each frame; a round-robin reference model predicts every grant and queues
// the expected response, which an independent monitor compares against the
// DUT's rsp_valid/rsp_data/err.
// -----------------------------------------------------------------------------
module tb_spi_cmd_arbiter;

   localparam int N = 4;
   localparam int W = 24;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1023;
`endif

   typedef struct {
      int         g;
      logic [W-1:0] d;
      logic       e;
   } rsp_t;

   logic           sys_clk;
   logic           n_rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ack;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_data;
   logic           err;
   logic [W-1:0]   spi_data;
   logic           spi_ena;
   logic           spi_busy;
   logic [W-1:0]   spi_miso;
   logic           spi_miso_ena;

   logic           mst_busy;
   logic [W-1:0]   mst_miso;
   logic           mst_miso_ena;
   logic           busy_frc;

   int             checks   = 0;
   int             failures = 0;
   int             ptr_m    = 0;
   int             mode     = 0;   // 0: drop on ack, 1: hold with new data, 2: random
   int             acks_seen = 0;
   int             rsp_cnt  = 0;
   int             last_g   = -1;
   bit             ack_now  = 0;
   bit             fixed_en = 0;
   logic [W-1:0]   fixed_word = '0;
   bit             stuck_to = 0;
   logic [W-1:0]   mst_q[$];
   rsp_t           exp_q[$];

   assign spi_busy     = mst_busy | busy_frc;
   assign spi_miso     = mst_miso;
   assign spi_miso_ena = mst_miso_ena;

   spi_cmd_arbiter #(
      .NUM_REQ     (N),
      .WIDTH       (W),
      .TIMEOUT_CYC (TO)
   ) dut (
      .sys_clk      (sys_clk),
      .n_rst        (n_rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ack      (req_ack),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .err          (err),
      .spi_data     (spi_data),
      .spi_ena      (spi_ena),
      .spi_busy     (spi_busy),
      .spi_miso     (spi_miso),
      .spi_miso_ena (spi_miso_ena)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      checks++;
      failures++;
      $display("FAIL %s: %s", name, why);
   endtask

   // One clock step. At the negedge the requester inputs still hold the values
   // the DUT saw at the previous posedge, so any ack is checked against them
   // before the requesters react.
   task automatic cycle();
      int g;
      int c;
      logic [W-1:0] w;
      rsp_t e;
      @(negedge sys_clk);
      ack_now = 0;
      if (n_rst && (req_ack != '0 || spi_ena)) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            c = (ptr_m + k) % N;
            if (g < 0 && req_valid[c]) g = c;
         end
         ack_now = 1;
         acks_seen++;
         if (g < 0) begin
            fail_now("ack_unrequested", $sformatf("req_ack=%b spi_ena=%b with req_valid=%b", req_ack, spi_ena, req_valid));
         end else begin
            check("ack_onehot", req_ack, 64'(1) << g);
            check("spi_ena", spi_ena, 1);
            check("spi_data", spi_data, req_data[g*W +: W]);
            check("busy_at_issue", spi_busy, 0);
            ptr_m  = (g + 1) % N;
            last_g = g;
            w = fixed_en ? fixed_word : W'($urandom);
            mst_q.push_back(w);
            e.g = g;
            e.d = stuck_to ? '0 : w;
            e.e = stuck_to;
            exp_q.push_back(e);
            stuck_to = 0;
            if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
               req_data[g*W +: W] = W'($urandom);
            end else begin
               req_valid[g] = 1'b0;
            end
         end
      end
      if (mode == 2) begin
         for (int i = 0; i < N; i++) begin
            if (!(ack_now && i == last_g)) begin
               if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                  req_valid[i]       = 1'b1;
                  req_data[i*W +: W] = W'($urandom);
               end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                  req_valid[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic wait_ack(input int budget, input string name);
      int n;
      n = 0;
      ack_now = 0;
      while (n < budget && !ack_now) begin
         cycle();
         n++;
      end
      if (!ack_now) fail_now(name, $sformatf("no req_ack within %0d cycles", budget));
   endtask

   task automatic wait_quiet(input int budget, input string name);
      int n;
      n = 0;
      while (n < budget && !(req_valid == '0 && exp_q.size() == 0 && !spi_busy && !spi_ena)) begin
         cycle();
         n++;
      end
      if (n >= budget) fail_now(name, $sformatf("not idle within %0d cycles", budget));
      cycle();
      cycle();
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      n_rst = 1'b0;
      repeat (2) @(negedge sys_clk);
      exp_q.delete();
      mst_q.delete();
      ptr_m = 0;
      n_rst = 1'b1;
   endtask

   // Behavioural SPI master: busy for frame+pause cycles, one MISO strobe
   // either inside the frame or on the busy-fall cycle.
   initial begin
      int d, f, p;
      bit same;
      logic [W-1:0] w;
      mst_busy     = 1'b0;
      mst_miso     = '0;
      mst_miso_ena = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (n_rst && spi_ena) begin
            @(posedge sys_clk);
            #1;
            w    = (mst_q.size() > 0) ? mst_q.pop_front() : '0;
            d    = $urandom_range(0, 1);
            f    = $urandom_range(2, 6);
            p    = $urandom_range(0, 3);
            same = ($urandom_range(0, 3) == 0);
            repeat (d) begin
               @(posedge sys_clk);
               #1;
            end
            mst_busy = 1'b1;
            for (int c = 0; c < f + p; c++) begin
               if (!same && c == f - 1) begin
                  mst_miso_ena = 1'b1;
                  mst_miso     = w;
               end else begin
                  mst_miso_ena = 1'b0;
                  mst_miso     = W'($urandom);
               end
               @(posedge sys_clk);
               #1;
            end
            mst_busy = 1'b0;
            if (same) begin
               mst_miso_ena = 1'b1;
               mst_miso     = w;
               @(posedge sys_clk);
               #1;
            end
            mst_miso_ena = 1'b0;
            mst_miso     = '0;
         end
      end
   end

   // Response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge sys_clk);
         if (n_rst && rsp_valid != '0) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
               fail_now("rsp_unexpected", $sformatf("rsp_valid=%b with no frame outstanding", rsp_valid));
            end else begin
               e = exp_q.pop_front();
               check("rsp_valid", rsp_valid, 64'(1) << e.g);
               check("rsp_data", rsp_data, e.d);
               check("rsp_err", err, e.e);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, r0, errs, lat, n;
      n_rst     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      busy_frc  = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("reset_outputs", {req_ack, rsp_valid, spi_ena, err, spi_data, rsp_data}, 0);
      n_rst = 1'b1;

      // 1: single command with fixed loopback word
      fixed_en   = 1;
      fixed_word = 24'hA5A5A5;
      @(negedge sys_clk);
      req_valid          = 4'b0001;
      req_data[0*W +: W] = 24'h801234;
      wait_ack(20, "t1_ack");
      check("t1_ack_idx", last_g, 0);
      wait_quiet(100, "t1_quiet");
      check("t1_rsp_count", rsp_cnt, 1);
      fixed_en = 0;

      // 2: all requesting, rotation from ptr 0
      do_reset();
      mode = 1;
      r0   = rsp_cnt;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_ack(40, "t2_ack");
         check("t2_order", last_g, k % N);
      end
      mode      = 0;
      req_valid = '0;
      wait_quiet(100, "t2_quiet");
      check("t2_rsp_count", rsp_cnt - r0, 8);

      // 3: no grant while busy, ack one cycle after the first busy-low cycle
      busy_frc           = 1'b1;
      req_valid          = 4'b0100;
      req_data[2*W +: W] = W'($urandom);
      a0 = acks_seen;
      repeat (10) cycle();
      check("t3_no_grant_busy", acks_seen - a0, 0);
      @(posedge sys_clk);
      #1;
      busy_frc = 1'b0;
      lat = 0;
      ack_now = 0;
      while (lat < 6 && !ack_now) begin
         cycle();
         lat++;
      end
      check("t3_ack_latency", lat, 2);
      wait_quiet(100, "t3_quiet");

      // 4: reset in WAIT_DONE aborts the frame and clears the pointer
      req_valid          = 4'b0001;
      req_data[0*W +: W] = W'($urandom);
      wait_ack(20, "t4_ack");
      n = 0;
      while (n < 5 && !spi_busy) begin
         cycle();
         n++;
      end
      cycle();
      n_rst = 1'b0;
      #1;
      check("t4_reset_outputs", {req_ack, rsp_valid, spi_ena, err, spi_data, rsp_data}, 0);
      r0 = rsp_cnt;
      repeat (2) @(negedge sys_clk);
      exp_q.delete();
      ptr_m = 0;
      n_rst = 1'b1;
      req_valid          = 4'b1001;
      req_data[0*W +: W] = W'($urandom);
      req_data[3*W +: W] = W'($urandom);
      wait_ack(40, "t4_ack_after");
      check("t4_winner", last_g, 0);
      wait_quiet(100, "t4_quiet");
      check("t4_no_aborted_rsp", rsp_cnt - r0, 1 + 1);

      // 6: requester 1 drops in the decision cycle; requester 2 is served
      a0 = acks_seen;
      for (int i = 0; i < 3; i++) req_data[i*W +: W] = W'($urandom);
      req_valid = 4'b0111;
      wait_ack(20, "t6_ack0");
      check("t6_first", last_g, 0);
      n = 0;
      while (n < 40 && rsp_valid == '0) begin
         cycle();
         n++;
      end
      req_valid[1] = 1'b0;
      wait_ack(20, "t6_ack2");
      check("t6_skip_dropped", last_g, 2);
      wait_quiet(100, "t6_quiet");
      check("t6_ack_count", acks_seen - a0, 2);

      // 5: busy stuck high after issue
`ifdef SPI_ARB_TIMEOUT_EN
      stuck_to = 1;
`endif
      req_valid          = 4'b0010;
      req_data[1*W +: W] = W'($urandom);
      wait_ack(20, "t5_ack");
      busy_frc = 1'b1;
      r0 = rsp_cnt;
      a0 = acks_seen;
      req_valid[3]       = 1'b1;
      req_data[3*W +: W] = W'($urandom);
      errs = 0;
      repeat (40) begin
         cycle();
         if (err) errs++;
      end
      check("t5_no_grant", acks_seen - a0, 0);
`ifdef SPI_ARB_TIMEOUT_EN
      check("t5_timeout_rsp", rsp_cnt - r0, 1);
      check("t5_err_pulses", errs, 1);
`else
      check("t5_hold_no_rsp", rsp_cnt - r0, 0);
      check("t5_no_err", errs, 0);
`endif
      busy_frc = 1'b0;
      wait_quiet(200, "t5_quiet");
      check("t5_rsp_total", rsp_cnt - r0, 2);

      // Random traffic against the round-robin model
      mode = 2;
      a0 = acks_seen;
      n  = 0;
      while (n < 6000 && acks_seen - a0 < 150) begin
         cycle();
         n++;
      end
      check("rand_progress", (acks_seen - a0 >= 150), 1);
      mode      = 0;
      req_valid = '0;
      wait_quiet(300, "rand_quiet");
      check("exp_drained", exp_q.size(), 0);
      check("rsp_vs_ack", rsp_cnt + 1, acks_seen);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
